adder_pipelined: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with N/Z/C/V flags and a valid/ready handshake on both sides. The WIDTH-bit operation is split into SEG-bit carry segments, one register stage per segment, giving one result per cycle at WIDTH/SEG cycles latency. It is the ALU-path and multi-cycle-datapath successor to the single-cycle flagged adder, for widths and clock rates where a single-cycle ripple is too slow.

---
 rtl/adder_pipelined_pkg.sv | 33 +++
 rtl/adder_seg.sv | 91 +++++++++
 rtl/adder_pipelined.sv | 127 ++++++++++++
 tb/tb_adder_pipelined.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipelined_pkg.sv
// adder_pipelined_pkg
// Shared definitions for the pipelined adder/subtractor:
//   DEF_WIDTH / DEF_SEG - default operand width and bits per carry segment
//   flags_t             - packed flag word in ALU flag-register order {n,z,c,v}
//   make_flags()        - builds the flag word from the final sum/carry bits
package adder_pipelined_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;

  // Bit 3 = n, bit 2 = z, bit 1 = c, bit 0 = v.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // Overflow: both addends share a sign and the result sign differs from it.
  function automatic flags_t make_flags(input logic sum_msb,
                                        input logic sum_zero,
                                        input logic carry_out,
                                        input logic a_msb,
                                        input logic b_eff_msb);
    flags_t f;
    f.n = sum_msb;
    f.z = sum_zero;
    f.c = carry_out;
    f.v = (a_msb == b_eff_msb) && (sum_msb != a_msb);
    return f;
  endfunction

endpackage

// File: rtl/adder_seg.sv
// adder_seg
// One pipeline stage of the segmented adder. Adds segment K of the operands
// with the incoming carry, then registers the operands, the partially built
// sum, the segment carry-out and a valid bit.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   up_valid / up_ready  - upstream handshake (up_ready = this stage advances)
//   up_a, up_b, up_s     - operand a, effective operand b, sum bits done so far
//   up_c                 - carry into this segment
//   dn_valid / dn_ready  - downstream handshake
//   dn_a, dn_b, dn_s, dn_c - registered stage contents
//   load                 - this stage captures new data this cycle
//   nxt_s, nxt_c         - combinational sum/carry being captured
`ifndef MYDELAY
`define MYDELAY
`endif

module adder_seg
  import adder_pipelined_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [WIDTH-1:0] up_s,
  input  logic             up_c,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_a,
  output logic [WIDTH-1:0] dn_b,
  output logic [WIDTH-1:0] dn_s,
  output logic             dn_c,
  output logic             load,
  output logic [WIDTH-1:0] nxt_s,
  output logic             nxt_c
);

  localparam int LO = K * SEG;

  logic [SEG:0]     seg_add;
  logic             valid_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] s_reg;
  logic             c_reg;

  assign seg_add = {1'b0, up_a[LO +: SEG]} + {1'b0, up_b[LO +: SEG]}
                 + {{SEG{1'b0}}, up_c};

  // Bits of up_s at and above this segment are still zero, so OR-ing the
  // shifted segment result in completes this slice of the sum.
  assign nxt_s = up_s | (WIDTH'(seg_add[SEG-1:0]) << LO);
  assign nxt_c = seg_add[SEG];

  // Advance when empty or when the downstream stage takes our contents.
  assign up_ready = !valid_reg || dn_ready;
  assign load     = up_ready && up_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= `MYDELAY 1'b0;
      a_reg     <= `MYDELAY '0;
      b_reg     <= `MYDELAY '0;
      s_reg     <= `MYDELAY '0;
      c_reg     <= `MYDELAY 1'b0;
    end else begin
      if (up_ready) begin
        valid_reg <= `MYDELAY up_valid;
      end
      if (load) begin
        a_reg <= `MYDELAY up_a;
        b_reg <= `MYDELAY up_b;
        s_reg <= `MYDELAY nxt_s;
        c_reg <= `MYDELAY nxt_c;
      end
    end
  end

  assign dn_valid = valid_reg;
  assign dn_a     = a_reg;
  assign dn_b     = b_reg;
  assign dn_s     = s_reg;
  assign dn_c     = c_reg;

endmodule

// File: rtl/adder_pipelined.sv
// adder_pipelined
// Pipelined two's-complement adder/subtractor with N/Z/C/V flags.
// sum = a + (sub ? ~b : b) + (cin ^ sub), one SEG-bit carry segment per
// stage, WIDTH/SEG stages, one result per cycle, valid/ready on both sides.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid / in_ready   - operand handshake
//   a, b, cin, sub        - operands, carry-in, subtract select
//   out_valid / out_ready - result handshake
//   sum, n, z, c, v       - result and flags (held while stalled)
`ifndef MYDELAY
`define MYDELAY
`endif

module adder_pipelined
  import adder_pipelined_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  // Element 0 is the stage-0 input, element k+1 the registers of stage k.
  logic             vld_w [0:STAGES];
  logic [WIDTH-1:0] a_w   [0:STAGES];
  logic [WIDTH-1:0] b_w   [0:STAGES];
  logic [WIDTH-1:0] s_w   [0:STAGES];
  logic             c_w   [0:STAGES];

  logic             rdy_up_w [0:STAGES-1];
  logic             ld_w     [0:STAGES-1];
  logic [WIDTH-1:0] nxt_s_w  [0:STAGES-1];
  logic             nxt_c_w  [0:STAGES-1];
  logic [STAGES-1:0] rdy_dn;

  flags_t flags_reg;

  assign vld_w[0] = in_valid;
  assign a_w[0]   = a;
  assign b_w[0]   = sub ? ~b : b;
  assign s_w[0]   = '0;
  assign c_w[0]   = cin ^ sub;

  // Downstream-ready for stage k, flattened: the output is taken, or some
  // later stage is empty and so absorbs the shift. Built from valid bits
  // only, so the chain never feeds back on itself.
  always_comb begin
    rdy_dn = '0;
    for (int k = 0; k < STAGES; k++) begin
      rdy_dn[k] = out_ready;
      for (int j = k + 1; j < STAGES; j++) begin
        if (!vld_w[j+1]) begin
          rdy_dn[k] = 1'b1;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_seg
      adder_seg #(
        .WIDTH (WIDTH),
        .SEG   (SEG),
        .K     (gi)
      ) u_seg (
        .clk      (clk),
        .reset    (reset),
        .up_valid (vld_w[gi]),
        .up_ready (rdy_up_w[gi]),
        .up_a     (a_w[gi]),
        .up_b     (b_w[gi]),
        .up_s     (s_w[gi]),
        .up_c     (c_w[gi]),
        .dn_valid (vld_w[gi+1]),
        .dn_ready (rdy_dn[gi]),
        .dn_a     (a_w[gi+1]),
        .dn_b     (b_w[gi+1]),
        .dn_s     (s_w[gi+1]),
        .dn_c     (c_w[gi+1]),
        .load     (ld_w[gi]),
        .nxt_s    (nxt_s_w[gi]),
        .nxt_c    (nxt_c_w[gi])
      );
    end
  endgenerate

  // Flags are captured alongside the last stage's sum so they stay aligned
  // with it and hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg <= `MYDELAY '0;
    end else if (ld_w[LAST]) begin
      flags_reg <= `MYDELAY make_flags(nxt_s_w[LAST][WIDTH-1],
                                       nxt_s_w[LAST] == '0,
                                       nxt_c_w[LAST],
                                       a_w[LAST][WIDTH-1],
                                       b_w[LAST][WIDTH-1]);
    end
  end

  assign in_ready  = rdy_up_w[0];
  assign out_valid = vld_w[STAGES];
  assign sum       = s_w[STAGES];
  assign n         = flags_reg.n;
  assign z         = flags_reg.z;
  assign c         = flags_reg.c;
  assign v         = flags_reg.v;

endmodule

// File: tb/tb_adder_pipelined.sv
module tb_adder_pipelined;

  localparam int W = 32;
  localparam int S = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, 4-stage instance
  logic          reset, in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic [W-1:0]  a, b, sum;
  logic          n, z, c, v;

  // 16-bit, single-stage instance
  logic          s_reset, s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready;
  logic [15:0]   s_a, s_b, s_sum;
  logic          s_n, s_z, s_c, s_v;

  adder_pipelined #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .n(n), .z(z), .c(c), .v(v));

  adder_pipelined #(.WIDTH(16), .SEG(16)) dut1 (
    .clk(clk), .reset(s_reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .sum(s_sum), .n(s_n), .z(s_z), .c(s_c), .v(s_v));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit two's-complement values.
  function automatic logic [35:0] model(input int w, input logic [31:0] aa, input logic [31:0] bb,
                                        input logic ci, input logic su);
    longint mask, ua, ub, be, full, half, sa, sb, sr, s;
    logic   n_, z_, c_, v_;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(aa) & mask;
    ub   = longint'(bb) & mask;
    be   = su ? (~ub & mask) : ub;
    full = ua + be + longint'(ci ^ su);
    s    = full & mask;
    c_   = ((full >> w) & 1) != 0;
    half = longint'(1) << (w - 1);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    sr   = su ? sa - sb - longint'(ci) : sa + sb + longint'(ci);
    v_   = (sr >= half) || (sr < -half);
    n_   = (s >= half);
    z_   = (s == 0);
    return {s[31:0], n_, z_, c_, v_};
  endfunction

  typedef struct {
    logic [35:0] res;
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        exp_q[$];
  int          pop_cyc[$];
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  bit          hold_prev = 1'b0;
  logic [35:0] hold_val;
  logic [35:0] last_res;

  // Scoreboard for the 32-bit instance, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [35:0] cur;
    cyc++;
    cur = {sum, n, z, c, v};
    if (reset) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("out_without_input", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("result", 64'(cur), 64'(e.res));
          if (lat_chk) check_eq("latency", 64'(cyc - e.cyc), 64'(S));
          pop_cyc.push_back(cyc);
          last_res = cur;
          $display("out a=%h b=%h sum=%h nzcv=%b%b%b%b", e.a, e.b, sum, n, z, c, v);
        end
      end
      if (out_valid && !out_ready) begin
        if (hold_prev) check_eq("stable", 64'(cur), 64'(hold_val));
        hold_prev = 1'b1;
        hold_val  = cur;
      end else begin
        hold_prev = 1'b0;
      end
      if (in_valid && in_ready) begin
        e.res = model(W, a, b, cin, sub);
        e.cyc = cyc;
        e.a   = a;
        e.b   = b;
        exp_q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] aa, input logic [31:0] bb, input logic ci, input logic su);
    in_valid = 1'b1;
    a = aa; b = bb; cin = ci; sub = su;
  endtask

  task automatic send_blocking(input logic [31:0] aa, input logic [31:0] bb, input logic ci, input logic su);
    logic acc;
    acc = 1'b0;
    drive(aa, bb, ci, su);
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    check_eq("accept_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) tick();
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    repeat (6) tick();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] dir_a   [5] = '{32'h7FFF_FFFF, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000};
  logic [31:0] dir_b   [5] = '{32'd1, 32'd5, 32'd5, 32'd1, 32'd1};
  logic        dir_cin [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic        dir_sub [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [35:0] dir_exp [5] = '{{32'h8000_0000, 4'b1001}, {32'h0000_0000, 4'b0110},
                               {32'hFFFF_FFFF, 4'b1000}, {32'h0000_0000, 4'b0110},
                               {32'h7FFF_FFFF, 4'b0011}};

  initial begin
    int   idx, acc_n;
    logic acc, first;

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    s_reset = 1'b1; s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0; s_out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0; s_reset = 1'b0;

    // Reset state
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_outputs", 64'({sum, n, z, c, v}), 64'd0);
    check_eq("rst16_out_valid", 64'(s_out_valid), 64'd0);
    check_eq("rst16_in_ready", 64'(s_in_ready), 64'd1);

    // Directed boundary vectors, one at a time into an empty pipe
    lat_chk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_blocking(dir_a[i], dir_b[i], dir_cin[i], dir_sub[i]);
      drain(20);
      check_eq($sformatf("plan_vec%0d", i), 64'(last_res), 64'(dir_exp[i]));
    end

    // Back-to-back stream
    pop_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      drive(32'(i), 32'(i) << 8, 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    drain(30);
    check_eq("b2b_count", 64'(pop_cyc.size()), 64'd10);
    if (pop_cyc.size() > 0) check_eq("b2b_span", 64'(pop_cyc[$] - pop_cyc[0]), 64'd9);

    // Backpressure: fill with out_ready low, then release
    lat_chk = 1'b0;
    out_ready = 1'b0;
    pop_cyc.delete();
    idx = 0; acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (idx < 6) drive(32'h100 + 32'(idx), 32'(idx) * 3, 1'b0, idx[0]);
      else in_valid = 1'b0;
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin idx++; acc_n++; end
    end
    check_eq("bp_accepts", 64'(acc_n), 64'(S));
    check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    first = 1'b1;
    for (int i = 0; i < 20 && idx < 6; i++) begin
      drive(32'h100 + 32'(idx), 32'(idx) * 3, 1'b0, idx[0]);
      @(negedge clk);
      if (first) check_eq("bp_ready_rise", 64'(in_ready), 64'd1);
      first = 1'b0;
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    drain(20);
    check_eq("bp_count", 64'(pop_cyc.size()), 64'd6);
    if (pop_cyc.size() > 0) check_eq("bp_span", 64'(pop_cyc[$] - pop_cyc[0]), 64'd5);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      a         = pick();
      b         = pick();
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(40);

    // Reset with three operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h5000 + 32'(i), 32'h1, 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_outputs", 64'({sum, n, z, c, v}), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    lat_chk = 1'b1;
    pop_cyc.delete();
    send_blocking(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0);
    drain(20);
    check_eq("midrst_count", 64'(pop_cyc.size()), 64'd1);
    check_eq("midrst_value", 64'(last_res), 64'({32'h0000_00FF, 4'b0000}));

    // Single-stage instance: latency 1
    s_in_valid = 1'b1; s_a = 16'hFFFF; s_b = 16'h0001; s_cin = 1'b0; s_sub = 1'b0;
    @(negedge clk);
    check_eq("s1_in_ready", 64'(s_in_ready), 64'd1);
    tick();
    s_in_valid = 1'b0;
    check_eq("s1_out_valid", 64'(s_out_valid), 64'd1);
    check_eq("s1_result", 64'({s_sum, s_n, s_z, s_c, s_v}), 64'({16'h0000, 4'b0110}));
    $display("out16 a=ffff b=0001 sum=%h nzcv=%b%b%b%b", s_sum, s_n, s_z, s_c, s_v);
    tick();
    check_eq("s1_out_idle", 64'(s_out_valid), 64'd0);

    // Single-stage instance: reset with one in flight
    s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_a = 16'h1234; s_b = 16'h0001; s_sub = 1'b1;
    tick();
    s_in_valid = 1'b0;
    check_eq("s1_held", 64'(s_out_valid), 64'd1);
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    check_eq("s1_rst_out_valid", 64'(s_out_valid), 64'd0);
    check_eq("s1_rst_outputs", 64'({s_sum, s_n, s_z, s_c, s_v}), 64'd0);
    s_in_valid = 1'b1; s_a = 16'h8000; s_b = 16'h0001; s_cin = 1'b0; s_sub = 1'b1;
    tick();
    s_in_valid = 1'b0;
    check_eq("s1_new_valid", 64'(s_out_valid), 64'd1);
    check_eq("s1_new_result", 64'({s_sum, s_n, s_z, s_c, s_v}),
             64'(model(16, 32'h8000, 32'h0001, 1'b0, 1'b1)));
    $display("out16 a=8000 b=0001 sub sum=%h nzcv=%b%b%b%b", s_sum, s_n, s_z, s_c, s_v);
    s_out_ready = 1'b1;
    tick();
    check_eq("s1_new_alone", 64'(s_out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not reach the end, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
